dma_copy_ctrl: RTL

//  Sequences one memory-to-memory copy over the CCI-P DMA channel: launches the read and write sides,

---
 rtl/dma_copy_ctrl_if.sv | 29 ++
 rtl/dma_copy_ctrl.sv | 86 ++++++++
 2 files changed

// File: rtl/dma_copy_ctrl_if.sv
// dma_copy_ctrl_if: DMA engine side of the copy controller (launch, read FIFO, write port, completion)
interface dma_copy_ctrl_if #(
    parameter int ADDR_WIDTH = 42,
    parameter int DATA_WIDTH = 512
);
    logic                  rd_go;
    logic                  wr_go;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH:0]   size;
    logic                  empty;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_en;
    logic                  full;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_done;
    logic                  wr_done;

    modport master (
        output rd_go, wr_go, rd_addr, wr_addr, size, rd_en, wr_en, wr_data,
        input  empty, rd_data, full, rd_done, wr_done
    );

    modport slave (
        input  rd_go, wr_go, rd_addr, wr_addr, size, rd_en, wr_en, wr_data,
        output empty, rd_data, full, rd_done, wr_done
    );
endinterface

// File: rtl/dma_copy_ctrl.sv
// dma_copy_ctrl: sequences one memory-to-memory copy, streaming read FIFO lines to the write port
module dma_copy_ctrl #(
    parameter int ADDR_WIDTH = 42,
    parameter int DATA_WIDTH = 512,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [ADDR_WIDTH:0]   size_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  cycles_o,
    dma_copy_ctrl_if.master       dma
);
    typedef enum logic [2:0] {IDLE, START, XFER, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic [ADDR_WIDTH:0]   size_q, remaining_q;
    logic [CNT_WIDTH-1:0]  cycles_q;
    logic                  done_q, launch_q;
    logic                  go_ok, xfer, active;
    logic [DATA_WIDTH-1:0] line;

    assign go_ok  = go_i && (state_q == IDLE || state_q == DONE);
    assign active = state_q == START || state_q == XFER || state_q == DRAIN;
    assign xfer   = state_q == XFER && !dma.empty && !dma.full && remaining_q != '0;
    assign line   = dma.rd_data;

    // State register; an asynchronous reset abandons any copy in flight
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;

    // Next state: a zero-length copy skips straight to DONE without launching the engine
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = go_ok ? (size_i == '0 ? DONE : START) : state_q;
            START:      state_d = XFER;
            XFER:       state_d = xfer && remaining_q == (ADDR_WIDTH+1)'(1) ? DRAIN : XFER;
            DRAIN:      state_d = dma.rd_done && dma.wr_done ? DONE : DRAIN;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs: pop and push happen together in the same cycle so no line is held or lost
    always_comb begin
        busy_o      = active;
        done_o      = done_q;
        cycles_o    = cycles_q;
        dma.rd_go   = launch_q;
        dma.wr_go   = launch_q;
        dma.rd_addr = rd_addr_q;
        dma.wr_addr = wr_addr_q;
        dma.size    = size_q;
        dma.rd_en   = xfer;
        dma.wr_en   = xfer;
        dma.wr_data = line;
    end

    // Datapath: parameters latched only on an accepted go, saturating cycle counter, line countdown
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            size_q      <= '0;
            remaining_q <= '0;
            cycles_q    <= '0;
            done_q      <= 1'b0;
            launch_q    <= 1'b0;
        end else begin
            if (go_ok) begin
                rd_addr_q <= rd_addr_i;
                wr_addr_q <= wr_addr_i;
                size_q    <= size_i;
            end
            cycles_q    <= go_ok ? '0 : (active && cycles_q != '1) ? cycles_q + CNT_WIDTH'(1) : cycles_q;
            done_q      <= !go_ok && state_q == DONE;
            launch_q    <= state_d == START;
            remaining_q <= state_q == START ? size_q : remaining_q - {{ADDR_WIDTH{1'b0}}, xfer};
        end
endmodule
